// File: rtl/period_meter.sv
// Measures the period (and optionally the high time) of an asynchronous signal in clk cycles.
// Optional feature macro: PERIOD_METER_HIGH_EN enables the high-time counter.
module period_meter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             ack,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             sync_d;
  logic             rise;
  logic             new_result;
  logic             to_event;
  logic [WIDTH-1:0] cnt;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= sig_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise       = sync2 & ~sync_d;
  assign new_result = (state == MEAS) & rise;
  assign to_event   = (state == MEAS) & ~rise & (cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      period <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEAS;
            cnt   <= ONE;
          end
        end
        MEAS: begin
          // A rise both closes the running period and opens the next one.
          if (rise) begin
            period <= cnt;
            cnt    <= ONE;
          end else if (cnt == TIMEOUT_CNT) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Status flags: a new set event wins over a simultaneous ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (new_result) begin
        valid <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
      end

      if (new_result && valid && !ack) begin
        overrun <= 1'b1;
      end else if (ack) begin
        overrun <= 1'b0;
      end

      if (to_event) begin
        timeout <= 1'b1;
      end else if (ack) begin
        timeout <= 1'b0;
      end
    end
  end

`ifdef PERIOD_METER_HIGH_EN
  logic [WIDTH-1:0] high_cnt;

  // The cycle that carries the rise is already high, so a fresh period starts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt  <= '0;
      high_time <= '0;
    end else begin
      if (rise) begin
        high_cnt <= ONE;
        if (state == MEAS) begin
          high_time <= high_cnt;
        end
      end else if (state == MEAS && !to_event) begin
        high_cnt <= high_cnt + {{(WIDTH-1){1'b0}}, sync2};
      end
    end
  end
`else
  assign high_time = '0;
`endif

endmodule
